// File: rtl/bytebasher_pkg.sv
// bytebasher_pkg
//   Shared definitions for the ByteBasher game controller: game state
//   encoding, the fixed image codes sent to the VGA fill unit, the box code
//   width and the target-selection helper.
package bytebasher_pkg;

  localparam int BOX_W = 3;

  localparam logic [BOX_W-1:0] MIF_LOBBY = 3'd0;
  localparam logic [BOX_W-1:0] MIF_OVER  = 3'd7;

  typedef enum logic [1:0] {
    ST_LOBBY = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } game_state_e;

  // Next lit box: take the random value when it is a legal box that differs
  // from the current one, otherwise step round-robin (cur mod num_boxes)+1.
  function automatic logic [BOX_W-1:0] pick_target(
    input logic [BOX_W-1:0] cur,
    input logic [BOX_W-1:0] lfsr,
    input logic [BOX_W-1:0] num_boxes
  );
    logic [BOX_W-1:0] nxt;
    if ((lfsr != 3'd0) && (lfsr <= num_boxes) && (lfsr != cur)) begin
      nxt = lfsr;
    end else if (cur >= num_boxes) begin
      nxt = 3'd1;
    end else begin
      nxt = cur + 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/hit_sync_edge.sv
// hit_sync_edge
//   Brings the asynchronous sensor code into the clock domain with a 2-flop
//   synchronizer, then an edge register that flags a hit only on a
//   zero -> non-zero transition, so a held sensor scores once.
//   Latency: input change sampled at edge N -> hit_evt valid after edge N+2.
// Ports
//   clk          in   1      system clock
//   rst_n        in   1      async active-low reset
//   box_address  in   3      raw sensor code (0 = no hit)
//   synced       out  3      synchronized code, aligned with hit_evt
//   hit_evt      out  1      one-cycle strobe for a new hit
module hit_sync_edge
  import bytebasher_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BOX_W-1:0] box_address,
  output logic [BOX_W-1:0] synced,
  output logic             hit_evt
);

  logic [BOX_W-1:0] sync1_r;
  logic [BOX_W-1:0] sync2_r;
  logic [BOX_W-1:0] synced_r;
  logic             hit_evt_r;

  // Synchronizer chain plus edge register; synced_r doubles as the
  // "previous value" for the edge test so hit_evt and synced line up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r   <= 3'd0;
      sync2_r   <= 3'd0;
      synced_r  <= 3'd0;
      hit_evt_r <= 1'b0;
    end else begin
      sync1_r   <= box_address;
      sync2_r   <= sync1_r;
      synced_r  <= sync2_r;
      hit_evt_r <= (sync2_r != 3'd0) && (synced_r == 3'd0);
    end
  end

  assign synced  = synced_r;
  assign hit_evt = hit_evt_r;

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer
//   ByteBasher top-level controller: LOBBY -> timed PLAY -> OVER.
//   Chooses the lit target box, scores synchronized sensor hits, pulses the
//   hit sound and enables the lobby music. All outputs are registered.
//   Optional build macro: MISS_PENALTY_EN -- a wrong-box hit decrements the
//   score (saturating at 0) and leaves the target unchanged.
// Ports
//   CLOCK_50           in   1        system clock
//   resetn             in   1        async active-low reset
//   start_game         in   1        debounced start key level (rising edge used)
//   box_address        in   3        sensor code, async to clock
//   lfsr_value         in   3        free-running random value
//   mif_control_signal out  3        0 lobby, 1..NUM_BOXES lit box, 7 game over
//   play_sound         out  1        hit-sound pulse
//   lobby_sound        out  1        lobby music enable
//   score              out  SCORE_W  current/final score
//   game_timer         out  6        seconds remaining
//   game_over          out  1        high in OVER
module game_sequencer
  import bytebasher_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int GAME_SECONDS = 60,
  parameter int DWELL_CYCLES = 75_000_000,
  parameter int SOUND_CYCLES = 5_000_000,
  parameter int NUM_BOXES    = 6,
  parameter int SCORE_W      = 11
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               start_game,
  input  logic [BOX_W-1:0]   box_address,
  input  logic [BOX_W-1:0]   lfsr_value,
  output logic [BOX_W-1:0]   mif_control_signal,
  output logic               play_sound,
  output logic               lobby_sound,
  output logic [SCORE_W-1:0] score,
  output logic [5:0]         game_timer,
  output logic               game_over
);

  localparam int TICK_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int SOUND_W = (SOUND_CYCLES > 1) ? $clog2(SOUND_CYCLES) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(CLK_HZ - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [SOUND_W-1:0] SOUND_LAST = SOUND_W'(SOUND_CYCLES - 1);
  localparam logic [5:0]         TIMER_INIT = 6'(GAME_SECONDS);
  localparam logic [BOX_W-1:0]   BOX_MAX    = BOX_W'(NUM_BOXES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

  game_state_e        state_r;
  logic               start_prev_r;
  logic [BOX_W-1:0]   target_r;
  logic [TICK_W-1:0]  tick_r;
  logic [DWELL_W-1:0] dwell_r;
  logic [SOUND_W-1:0] sound_cnt_r;
  logic [BOX_W-1:0]   mif_r;
  logic               play_sound_r;
  logic               lobby_sound_r;
  logic [SCORE_W-1:0] score_r;
  logic [5:0]         timer_r;
  logic               game_over_r;

  logic [BOX_W-1:0]   synced_s;
  logic               hit_evt_s;
  logic               start_rise_s;
  logic               hit_correct_s;
  logic [BOX_W-1:0]   next_target_s;
  logic [BOX_W-1:0]   first_target_s;
`ifdef MISS_PENALTY_EN
  logic               hit_wrong_s;
`endif

  hit_sync_edge u_hit_sync_edge (
    .clk         (CLOCK_50),
    .rst_n       (resetn),
    .box_address (box_address),
    .synced      (synced_s),
    .hit_evt     (hit_evt_s)
  );

  // Decode start edge, hit classification and candidate targets.
  always_comb begin
    start_rise_s   = start_game & ~start_prev_r;
    next_target_s  = pick_target(target_r, lfsr_value, BOX_MAX);
    first_target_s = pick_target(3'd0, lfsr_value, BOX_MAX);
    if (hit_evt_s && (synced_s == target_r)) begin
      hit_correct_s = 1'b1;
    end else begin
      hit_correct_s = 1'b0;
    end
`ifdef MISS_PENALTY_EN
    if (hit_evt_s && (synced_s != target_r)) begin
      hit_wrong_s = 1'b1;
    end else begin
      hit_wrong_s = 1'b0;
    end
`endif
  end

  // Game FSM with all registered outputs and counters.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_r       <= ST_LOBBY;
      start_prev_r  <= 1'b0;
      target_r      <= 3'd0;
      tick_r        <= '0;
      dwell_r       <= '0;
      sound_cnt_r   <= '0;
      mif_r         <= MIF_LOBBY;
      play_sound_r  <= 1'b0;
      lobby_sound_r <= 1'b1;
      score_r       <= '0;
      timer_r       <= TIMER_INIT;
      game_over_r   <= 1'b0;
    end else begin
      start_prev_r <= start_game;

      // Sound pulse runs down in every state so it can finish after PLAY.
      if (sound_cnt_r != '0) begin
        sound_cnt_r <= sound_cnt_r - SOUND_W'(1);
      end else begin
        play_sound_r <= 1'b0;
      end

      case (state_r)
        ST_LOBBY: begin
          lobby_sound_r <= 1'b1;
          mif_r         <= MIF_LOBBY;
          game_over_r   <= 1'b0;
          if (start_rise_s) begin
            state_r       <= ST_PLAY;
            score_r       <= '0;
            timer_r       <= TIMER_INIT;
            tick_r        <= '0;
            dwell_r       <= '0;
            lobby_sound_r <= 1'b0;
            target_r      <= first_target_s;
            mif_r         <= first_target_s;
          end
        end

        ST_PLAY: begin
          if (tick_r == TICK_LAST) begin
            tick_r <= '0;
            if (timer_r != 6'd0) begin
              timer_r <= timer_r - 6'd1;
            end
          end else begin
            tick_r <= tick_r + TICK_W'(1);
          end

          // A hit takes priority over dwell expiry: one target change only.
          if (hit_correct_s) begin
            if (score_r != SCORE_MAX) begin
              score_r <= score_r + SCORE_ONE;
            end
            sound_cnt_r  <= SOUND_LAST;
            play_sound_r <= 1'b1;
            target_r     <= next_target_s;
            mif_r        <= next_target_s;
            dwell_r      <= '0;
          end else if (dwell_r == DWELL_LAST) begin
            target_r <= next_target_s;
            mif_r    <= next_target_s;
            dwell_r  <= '0;
          end else begin
            dwell_r <= dwell_r + DWELL_W'(1);
          end

`ifdef MISS_PENALTY_EN
          if (hit_wrong_s && (score_r != '0)) begin
            score_r <= score_r - SCORE_ONE;
          end
`endif

          // Timer already at zero: leave next edge; a hit this cycle still counts.
          if (timer_r == 6'd0) begin
            state_r     <= ST_OVER;
            mif_r       <= MIF_OVER;
            game_over_r <= 1'b1;
          end
        end

        ST_OVER: begin
          mif_r       <= MIF_OVER;
          game_over_r <= 1'b1;
          if (start_rise_s) begin
            state_r       <= ST_LOBBY;
            mif_r         <= MIF_LOBBY;
            game_over_r   <= 1'b0;
            lobby_sound_r <= 1'b1;
          end
        end

        default: begin
          state_r       <= ST_LOBBY;
          mif_r         <= MIF_LOBBY;
          game_over_r   <= 1'b0;
          lobby_sound_r <= 1'b1;
        end
      endcase
    end
  end

  assign mif_control_signal = mif_r;
  assign play_sound         = play_sound_r;
  assign lobby_sound        = lobby_sound_r;
  assign score              = score_r;
  assign game_timer         = timer_r;
  assign game_over          = game_over_r;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer
//   Directed bench for game_sequencer with small timing parameters and a
//   3-bit score so saturation is reachable. Inputs change on the falling
//   edge; outputs are sampled on the falling edge after the active edge.
module tb_game_sequencer;

  localparam int SW = 3;

  logic          clk;
  logic          rst_n;
  logic          start_game;
  logic [2:0]    box_address;
  logic [2:0]    lfsr_value;
  logic [2:0]    mif;
  logic          play_sound;
  logic          lobby_sound;
  logic [SW-1:0] score;
  logic [5:0]    game_timer;
  logic          game_over;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [2:0]    box;
    logic [2:0]    lfsr;
    logic [2:0]    exp_mif;
    logic [SW-1:0] exp_score;
    logic          exp_ps;
  } vec_t;

  vec_t vecs [5];

  game_sequencer #(
    .CLK_HZ       (10),
    .GAME_SECONDS (3),
    .DWELL_CYCLES (20),
    .SOUND_CYCLES (4),
    .NUM_BOXES    (6),
    .SCORE_W      (SW)
  ) dut (
    .CLOCK_50           (clk),
    .resetn             (rst_n),
    .start_game         (start_game),
    .box_address        (box_address),
    .lfsr_value         (lfsr_value),
    .mif_control_signal (mif),
    .play_sound         (play_sound),
    .lobby_sound        (lobby_sound),
    .score              (score),
    .game_timer         (game_timer),
    .game_over          (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start_play(input logic [2:0] l);
    start_game = 1'b0;
    step();
    start_game = 1'b1;
    lfsr_value = l;
    step();
    start_game = 1'b0;
  endtask

  initial begin
    int ps_cnt;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start_game = 1'b0;
    box_address = 3'd0;
    lfsr_value = 3'd0;

    //                 box    lfsr   mif    score  ps
    vecs[0] = '{3'd1, 3'd1, 3'd2, 3'd1, 1'b1};
    vecs[1] = '{3'd2, 3'd5, 3'd5, 3'd2, 1'b1};
`ifdef MISS_PENALTY_EN
    vecs[2] = '{3'd4, 3'd0, 3'd5, 3'd1, 1'b0};
    vecs[3] = '{3'd5, 3'd7, 3'd6, 3'd2, 1'b1};
    vecs[4] = '{3'd6, 3'd0, 3'd1, 3'd3, 1'b1};
`else
    vecs[2] = '{3'd4, 3'd0, 3'd5, 3'd2, 1'b0};
    vecs[3] = '{3'd5, 3'd7, 3'd6, 3'd3, 1'b1};
    vecs[4] = '{3'd6, 3'd0, 3'd1, 3'd4, 1'b1};
`endif

    // Reset state
    @(negedge clk);
    step();
    check("rst_mif", mif, 0);
    check("rst_lobby_sound", lobby_sound, 1);
    check("rst_play_sound", play_sound, 0);
    check("rst_score", score, 0);
    check("rst_timer", game_timer, 3);
    check("rst_game_over", game_over, 0);
    rst_n = 1'b1;
    step();

    // Game 1: held hit, dwell advance, timer expiry with a hit in that cycle
    start_play(3'd0);
    check("g1_entry_mif", mif, 1);
    check("g1_entry_lobby", lobby_sound, 0);
    check("g1_entry_timer", game_timer, 3);
    box_address = 3'd1;
    repeat (3) step();
    check("held_pre_score", score, 0);
    step();
    check("held_score", score, 1);
    check("held_ps", play_sound, 1);
    check("held_mif", mif, 2);
    ps_cnt = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) box_address = 3'd0;
      ps_cnt += int'(play_sound);
    end
    check("held_ps_len", ps_cnt, 4);
    check("held_once_score", score, 1);
    check("timer_2", game_timer, 2);
    repeat (10) step();
    check("timer_1", game_timer, 1);
    repeat (4) step();
    check("dwell_adv_mif", mif, 3);
    repeat (3) step();
    box_address = 3'd3;
    step();
    box_address = 3'd0;
    repeat (2) step();
    check("timer_0", game_timer, 0);
    check("timer_0_not_over", game_over, 0);
    step();
    check("over_flag", game_over, 1);
    check("over_mif", mif, 7);
    check("expiry_hit_score", score, 2);
    box_address = 3'd3;
    step();
    box_address = 3'd0;
    repeat (4) step();
    check("over_hit_ignored", score, 2);
    start_game = 1'b1;
    step();
    start_game = 1'b0;
    check("lobby_mif", mif, 0);
    check("lobby_sound_on", lobby_sound, 1);
    check("lobby_game_over", game_over, 0);
    check("lobby_score_held", score, 2);

    // Game 2: table of hits and target selections
    start_play(3'd0);
    check("g2_entry_score", score, 0);
    for (int i = 0; i < 5; i++) begin
      box_address = vecs[i].box;
      lfsr_value = vecs[i].lfsr;
      step();
      box_address = 3'd0;
      repeat (3) step();
      check($sformatf("vec%0d_mif", i), mif, int'(vecs[i].exp_mif));
      check($sformatf("vec%0d_score", i), score, int'(vecs[i].exp_score));
      check($sformatf("vec%0d_ps", i), play_sound, int'(vecs[i].exp_ps));
    end
    start_game = 1'b1;
    step();
    start_game = 1'b0;
    check("play_start_ignored_over", game_over, 0);
    check("play_start_ignored_mif", mif, 1);
    check("play_timer_1", game_timer, 1);
    rst_n = 1'b0;
    step();
    check("midplay_rst_mif", mif, 0);
    check("midplay_rst_lobby", lobby_sound, 1);
    check("midplay_rst_score", score, 0);
    check("midplay_rst_timer", game_timer, 3);
    rst_n = 1'b1;
    step();

    // Game 3: dwell expiry with lfsr equal to the target falls back
    start_play(3'd3);
    check("g3_entry_mif", mif, 3);
    repeat (19) step();
    check("dwell_hold_mif", mif, 3);
    step();
    check("dwell_fallback_mif", mif, 4);
    check("dwell_score", score, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Game 4: score saturation
    start_play(3'd0);
    for (int k = 0; k < 7; k++) begin
      box_address = 3'((k % 6) + 1);
      step();
      box_address = 3'd0;
      step();
    end
    repeat (2) step();
    check("sat_reach", score, 7);
    repeat (4) step();
    check("sat_ps_idle", play_sound, 0);
    box_address = 3'd2;
    step();
    box_address = 3'd0;
    repeat (3) step();
    check("sat_hold", score, 7);
    check("sat_ps", play_sound, 1);
    check("sat_mif", mif, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
